// File: rtl/mem_bram_responder_if.sv
// mem_* request interface between an initiator (master) and a responder (slave).
// Signal names follow the responder's point of view (_i into the responder, _o out of it).
interface mem_bram_responder_if #(
    parameter int unsigned addr_width_g = 10,
    parameter int unsigned data_width_g = 16
);
    logic [addr_width_g-1:0] addr_i;
    logic                    rd_en_i;
    logic                    wr_en_i;
    logic [data_width_g-1:0] data_i;
    logic [data_width_g-1:0] data_o;
    logic                    data_en_o;
    logic                    busy_o;
    logic                    done_o;
    logic [addr_width_g-1:0] fault_addr_i;
    logic [data_width_g-1:0] fault_mask_i;

    modport master (
        output addr_i, rd_en_i, wr_en_i, data_i, fault_addr_i, fault_mask_i,
        input  data_o, data_en_o, busy_o, done_o
    );

    modport slave (
        input  addr_i, rd_en_i, wr_en_i, data_i, fault_addr_i, fault_mask_i,
        output data_o, data_en_o, busy_o, done_o
    );
endinterface

// File: rtl/mem_bram_responder.sv
// Block-RAM backed responder for the mem_* request interface, with programmable
// wait states ahead of the RAM access.
// Optional read-fault injection: define MEM_BRAM_RESPONDER_FAULT_INJ_EN.
module mem_bram_responder #(
    parameter int unsigned addr_width_g = 10,
    parameter int unsigned data_width_g = 16,
    parameter int unsigned num_delay_g  = 2
) (
    input logic             clk_i,
    input logic             rst_syn_i,
    mem_bram_responder_if.slave bus
);
    localparam int unsigned ram_depth = 2 ** addr_width_g;

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_wait   = 2'd1;
    localparam logic [1:0] st_access = 2'd2;
    localparam logic [1:0] st_done   = 2'd3;

    // With no wait states the request goes straight to the RAM access.
    localparam logic [1:0] first_state = (num_delay_g > 0) ? st_wait : st_access;
    localparam int unsigned delay_load = (num_delay_g > 0) ? num_delay_g - 1 : 0;
    localparam logic [3:0] delay_init  = 4'(delay_load);

    logic [data_width_g-1:0] ram [ram_depth];

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [3:0]              delay_cnt;
    logic [addr_width_g-1:0] req_addr;
    logic [data_width_g-1:0] req_data;
    logic                    req_wr;
    logic [data_width_g-1:0] rd_word;
    logic [data_width_g-1:0] fault_xor;
    logic                    accept;

    // Requests are taken whenever the responder is not busy (IDLE or DONE).
    assign accept = ((state == st_idle) || (state == st_done)) && (bus.rd_en_i || bus.wr_en_i);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            st_idle:   if (accept) state_nxt = first_state;
            st_wait:   if (delay_cnt == 4'd0) state_nxt = st_access;
            st_access: state_nxt = st_done;
            st_done:   state_nxt = accept ? first_state : st_idle;
            default:   state_nxt = st_idle;
        endcase
    end

    // FSM state, wait counter and request capture.
    always_ff @(posedge clk_i) begin
        if (rst_syn_i) begin
            state     <= st_idle;
            delay_cnt <= 4'd0;
            req_addr  <= '0;
            req_data  <= '0;
            req_wr    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                delay_cnt <= delay_init;
                req_addr  <= bus.addr_i;
                req_data  <= bus.data_i;
                // A simultaneous read+write is a write.
                req_wr    <= bus.wr_en_i;
            end else if ((state == st_wait) && (delay_cnt != 4'd0)) begin
                delay_cnt <= delay_cnt - 4'd1;
            end
        end
    end

`ifdef MEM_BRAM_RESPONDER_FAULT_INJ_EN
    // Flip the selected bits of the returned word only; the RAM keeps the true value.
    assign fault_xor = (req_addr == bus.fault_addr_i) ? bus.fault_mask_i : '0;
`else
    logic unused_fault;
    assign unused_fault = ^{bus.fault_addr_i, bus.fault_mask_i};
    assign fault_xor    = '0;
`endif

    // RAM write port; reset on the ACCESS edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (!rst_syn_i && (state == st_access) && req_wr) begin
            ram[req_addr] <= req_data;
        end
    end

    // Registered read word; holds until the next read completes.
    always_ff @(posedge clk_i) begin
        if (rst_syn_i) begin
            rd_word <= '0;
        end else if ((state == st_access) && !req_wr) begin
            rd_word <= ram[req_addr] ^ fault_xor;
        end
    end

    // Handshake outputs decoded from the FSM state.
    always_comb begin
        bus.busy_o    = (state == st_wait) || (state == st_access);
        bus.done_o    = (state == st_done);
        bus.data_en_o = (state == st_done) && !req_wr;
        bus.data_o    = rd_word;
    end
endmodule

// File: tb/tb_mem_bram_responder.sv
// Directed self-checking bench for mem_bram_responder (default num_delay_g = 2).
// Fault-injection expectations follow MEM_BRAM_RESPONDER_FAULT_INJ_EN.
module tb_mem_bram_responder;
    logic clk_i = 1'b0;
    logic rst_syn_i;

    int n_assert = 0;
    int n_fail   = 0;

    mem_bram_responder_if #(.addr_width_g(10), .data_width_g(16)) bus ();

    mem_bram_responder #(
        .addr_width_g(10),
        .data_width_g(16),
        .num_delay_g (2)
    ) dut (
        .clk_i    (clk_i),
        .rst_syn_i(rst_syn_i),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request in the current cycle (cycle 0) and wait for done_o.
    task automatic do_op(input logic wr, input logic rd, input logic [9:0] a,
                         input logic [15:0] d, output int lat, output logic den,
                         output logic [15:0] q);
        bus.addr_i  = a;
        bus.data_i  = d;
        bus.wr_en_i = wr;
        bus.rd_en_i = rd;
        lat = -1;
        den = 1'b0;
        q   = 16'h0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) begin
                bus.wr_en_i = 1'b0;
                bus.rd_en_i = 1'b0;
            end
            if (bus.done_o) begin
                lat = c;
                den = bus.data_en_o;
                q   = bus.data_o;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (bus.done_o) cnt++;
        end
    endtask

    int          lat;
    int          ndone;
    logic        den;
    logic [15:0] q;
    logic [15:0] exp_fault;

    initial begin
        rst_syn_i        = 1'b1;
        bus.addr_i       = '0;
        bus.data_i       = '0;
        bus.rd_en_i      = 1'b0;
        bus.wr_en_i      = 1'b0;
        bus.fault_addr_i = 10'h3FF;
        bus.fault_mask_i = 16'h0000;
        repeat (3) tick();

        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_data_en", 32'(bus.data_en_o), 32'd0);
        chk("rst_data", 32'(bus.data_o), 32'h0);
        rst_syn_i = 1'b0;
        tick();

        // Write then read back, latency num_delay_g + 2 = 4.
        do_op(1'b1, 1'b0, 10'h003, 16'hAA33, lat, den, q);
        chk("wr_lat", 32'(lat), 32'd4);
        chk("wr_no_data_en", 32'(den), 32'd0);
        chk("wr_data_o_unchanged", 32'(bus.data_o), 32'h0);
        do_op(1'b0, 1'b1, 10'h003, 16'h0000, lat, den, q);
        chk("rd_lat", 32'(lat), 32'd4);
        chk("rd_data_en", 32'(den), 32'd1);
        chk("rd_data", 32'(q), 32'hAA33);
        tick();
        chk("data_en_one_cycle", 32'(bus.data_en_o), 32'd0);
        chk("data_o_hold", 32'(bus.data_o), 32'hAA33);

        // Second write while busy is dropped.
        bus.addr_i  = 10'h010;
        bus.data_i  = 16'h1234;
        bus.wr_en_i = 1'b1;
        tick();
        chk("busy_after_accept", 32'(bus.busy_o), 32'd1);
        bus.data_i = 16'hFFFF;
        tick();
        bus.wr_en_i = 1'b0;
        count_done(8, ndone);
        chk("busy_ignore_done_count", 32'(ndone), 32'd1);
        do_op(1'b0, 1'b1, 10'h010, 16'h0000, lat, den, q);
        chk("busy_ignore_readback", 32'(q), 32'h1234);

        // Back-to-back reads, each issued in the previous DONE cycle.
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 1'b1, 10'h003, 16'h0000, lat, den, q);
            chk($sformatf("b2b_spacing_%0d", i), 32'(lat), 32'd4);
            chk($sformatf("b2b_data_%0d", i), 32'(q), 32'hAA33);
        end

        // Simultaneous read+write acts as a write.
        do_op(1'b1, 1'b1, 10'h020, 16'h5A5A, lat, den, q);
        chk("simul_lat", 32'(lat), 32'd4);
        chk("simul_no_data_en", 32'(den), 32'd0);
        chk("simul_data_o_hold", 32'(bus.data_o), 32'hAA33);
        do_op(1'b0, 1'b1, 10'h020, 16'h0000, lat, den, q);
        chk("simul_readback", 32'(q), 32'h5A5A);

        // Reset while waiting discards the write.
        do_op(1'b1, 1'b0, 10'h030, 16'h0000, lat, den, q);
        bus.addr_i  = 10'h030;
        bus.data_i  = 16'hBEEF;
        bus.wr_en_i = 1'b1;
        tick();
        bus.wr_en_i = 1'b0;
        rst_syn_i   = 1'b1;
        tick();
        rst_syn_i = 1'b0;
        chk("rst_mid_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_mid_done", 32'(bus.done_o), 32'd0);
        chk("rst_mid_data_o", 32'(bus.data_o), 32'h0);
        count_done(8, ndone);
        chk("rst_mid_no_done", 32'(ndone), 32'd0);
        do_op(1'b0, 1'b1, 10'h030, 16'h0000, lat, den, q);
        chk("rst_mid_readback", 32'(q), 32'h0000);

        // Reset on the ACCESS edge also discards the write.
        do_op(1'b1, 1'b0, 10'h031, 16'h1111, lat, den, q);
        bus.addr_i  = 10'h031;
        bus.data_i  = 16'h2222;
        bus.wr_en_i = 1'b1;
        tick();
        bus.wr_en_i = 1'b0;
        tick();
        tick();
        chk("access_busy", 32'(bus.busy_o), 32'd1);
        rst_syn_i = 1'b1;
        tick();
        rst_syn_i = 1'b0;
        chk("rst_access_done", 32'(bus.done_o), 32'd0);
        do_op(1'b0, 1'b1, 10'h031, 16'h0000, lat, den, q);
        chk("rst_access_readback", 32'(q), 32'h1111);

        // Fault injection on address 0x003.
        do_op(1'b1, 1'b0, 10'h004, 16'h0F0F, lat, den, q);
        bus.fault_addr_i = 10'h003;
        bus.fault_mask_i = 16'h0001;
`ifdef MEM_BRAM_RESPONDER_FAULT_INJ_EN
        exp_fault = 16'hAA32;
`else
        exp_fault = 16'hAA33;
`endif
        do_op(1'b0, 1'b1, 10'h003, 16'h0000, lat, den, q);
        chk("fault_read", 32'(q), 32'(exp_fault));
        do_op(1'b0, 1'b1, 10'h004, 16'h0000, lat, den, q);
        chk("fault_other_addr", 32'(q), 32'h0F0F);
        bus.fault_mask_i = 16'h0000;
        do_op(1'b0, 1'b1, 10'h003, 16'h0000, lat, den, q);
        chk("fault_ram_intact", 32'(q), 32'hAA33);

        // Extreme addresses.
        do_op(1'b1, 1'b0, 10'h3FF, 16'hC3C3, lat, den, q);
        do_op(1'b1, 1'b0, 10'h000, 16'h0101, lat, den, q);
        do_op(1'b0, 1'b1, 10'h3FF, 16'h0000, lat, den, q);
        chk("addr_top", 32'(q), 32'hC3C3);
        do_op(1'b0, 1'b1, 10'h000, 16'h0000, lat, den, q);
        chk("addr_zero", 32'(q), 32'h0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
